// File: rtl/io_bridge_pkg.sv
// Shared types and defaults for the core-to-peripheral IO bridge.
package io_bridge_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int          CNT_WIDTH         = 8;
    localparam logic [15:0] ERR_VALUE_DEFAULT = 16'hDEAD;
    localparam logic [3:0]  IO_BASE_DEFAULT   = 4'hF;

endpackage

// File: rtl/io_bridge_if.sv
// Core data port, RAM and peripheral channel signals seen by the IO bridge.
interface io_bridge_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_WIDTH  = 19,
    parameter int IO_WIDTH   = 16,
    parameter int NUM_PORTS  = 4
);
    logic [ADDR_WIDTH-1:0]          core_addr;
    logic                           core_valid;
    logic                           core_write;
    logic [MEM_WIDTH-1:0]           core_wdata;
    logic [MEM_WIDTH-1:0]           core_rdata;
    logic                           core_stall;
    logic                           ram_write;
    logic [MEM_WIDTH-1:0]           ram_rdata;
    logic [NUM_PORTS-1:0]           io_sel;
    logic [11:0]                    io_index;
    logic                           io_read;
    logic                           io_write;
    logic [IO_WIDTH-1:0]            io_wdata;
    logic [NUM_PORTS*IO_WIDTH-1:0]  io_rdata;
    logic [NUM_PORTS-1:0]           io_ready;
    logic                           bus_error;
    logic [3:0]                     err_port;

    // Environment side: core, RAM and peripherals.
    modport master (
        output core_addr, core_valid, core_write, core_wdata, ram_rdata,
               io_rdata, io_ready,
        input  core_rdata, core_stall, ram_write, io_sel, io_index, io_read,
               io_write, io_wdata, bus_error, err_port
    );

    // Bridge side.
    modport slave (
        input  core_addr, core_valid, core_write, core_wdata, ram_rdata,
               io_rdata, io_ready,
        output core_rdata, core_stall, ram_write, io_sel, io_index, io_read,
               io_write, io_wdata, bus_error, err_port
    );
endinterface

// File: rtl/io_bridge_io_read_mux.sv
// Selects one peripheral's read slice and zero-extends it to the core word width.
module io_read_mux #(
    parameter int NUM_PORTS = 4,
    parameter int IO_WIDTH  = 16,
    parameter int MEM_WIDTH = 19,
    parameter int PORT_BITS = 2
) (
    input  logic [NUM_PORTS*IO_WIDTH-1:0] rdata,
    input  logic [PORT_BITS-1:0]          port,
    output logic [MEM_WIDTH-1:0]          data
);

    always_comb begin
        data = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (32'(port) == p) begin
                data[IO_WIDTH-1:0] = rdata[p*IO_WIDTH +: IO_WIDTH];
            end
        end
    end

endmodule

// File: rtl/io_bridge.sv
// IO window decode, per-channel ready handshake with timeout, and read-data
// return path that matches the one-cycle RAM read latency.
//
// state | meaning
// IDLE  | no access outstanding; zero-wait completions happen here
// WAIT  | IO access stalled, counting cycles until ready or timeout
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int                ADDR_WIDTH     = 16,
    parameter int                MEM_WIDTH      = 19,
    parameter int                IO_WIDTH       = 16,
    parameter logic [3:0]        IO_BASE        = IO_BASE_DEFAULT,
    parameter int                NUM_PORTS      = 4,
    parameter int                PORT_BITS      = 2,
    parameter int                TIMEOUT_CYCLES = 15,
    parameter logic [IO_WIDTH-1:0] ERR_VALUE    = ERR_VALUE_DEFAULT
) (
    input  logic      clk,
    input  logic      reset,
    io_bridge_if.slave bus
);

    state_t                 state, state_nxt;
    logic [CNT_WIDTH-1:0]   cnt, cnt_nxt;
    logic [PORT_BITS-1:0]   port;
    logic [NUM_PORTS-1:0]   sel;
    logic                   in_io, mapped, ready_sel;
    logic                   complete, is_err, stall;
    logic                   last_was_io, bus_error_q;
    logic [3:0]             err_port_q;
    logic [MEM_WIDTH-1:0]   io_data, mux_data;
    logic                   unused_wdata;

    assign in_io     = bus.core_valid && (bus.core_addr[ADDR_WIDTH-1 -: 4] == IO_BASE);
    assign port      = bus.core_addr[11 -: PORT_BITS];
    assign mapped    = 32'(port) < 32'(NUM_PORTS);
    assign ready_sel = |(sel & bus.io_ready);

    always_comb begin
        sel = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            sel[p] = in_io && (32'(port) == p);
        end
    end

    io_read_mux #(
        .NUM_PORTS (NUM_PORTS),
        .IO_WIDTH  (IO_WIDTH),
        .MEM_WIDTH (MEM_WIDTH),
        .PORT_BITS (PORT_BITS)
    ) u_read_mux (
        .rdata (bus.io_rdata),
        .port  (port),
        .data  (mux_data)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        complete  = 1'b0;
        is_err    = 1'b0;
        case (state)
            IDLE: begin
                if (in_io) begin
                    if (!mapped) begin
                        complete = 1'b1;
                        is_err   = 1'b1;
                    end else if (ready_sel) begin
                        complete = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_WIDTH'(1);
                    end
                end
            end
            WAIT: begin
                // A dropped request abandons the access without completing it.
                if (!in_io) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (ready_sel) begin
                    complete = 1'b1;
                end else if (cnt == CNT_WIDTH'(TIMEOUT_CYCLES)) begin
                    complete = 1'b1;
                    is_err   = 1'b1;
                end else begin
                    stall   = 1'b1;
                    cnt_nxt = cnt + CNT_WIDTH'(1);
                end
                if (complete) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            last_was_io <= 1'b0;
            io_data     <= '0;
            bus_error_q <= 1'b0;
            err_port_q  <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            last_was_io <= complete;
            bus_error_q <= complete && is_err;
            if (complete && is_err) begin
                err_port_q <= 4'(port);
            end
            if (complete && !bus.core_write) begin
                io_data <= is_err ? MEM_WIDTH'(ERR_VALUE) : mux_data;
            end
        end
    end

    assign bus.core_stall = stall && !reset;
    assign bus.io_sel     = reset ? '0 : sel;
    assign bus.io_read    = !reset && in_io && mapped && !bus.core_write;
    assign bus.io_write   = !reset && in_io && mapped && bus.core_write;
    assign bus.ram_write  = !reset && bus.core_valid && bus.core_write && !in_io;
    assign bus.io_index   = bus.core_addr[11:0];
    assign bus.io_wdata   = bus.core_wdata[IO_WIDTH-1:0];
    assign bus.core_rdata = last_was_io ? io_data : bus.ram_rdata;
    assign bus.bus_error  = bus_error_q;
    assign bus.err_port   = err_port_q;

    assign unused_wdata = ^bus.core_wdata[MEM_WIDTH-1:IO_WIDTH];

endmodule

// File: tb/tb_io_bridge.sv
// Directed bench for io_bridge with a cycle-level reference model and a
// second instance configured with three ports for the unmapped-port case.
module tb_io_bridge;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    io_bridge_if #(.NUM_PORTS(4)) bus  ();
    io_bridge_if #(.NUM_PORTS(3)) bus3 ();

    io_bridge #(.NUM_PORTS(4), .PORT_BITS(2), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk (clk), .reset (reset), .bus (bus.slave)
    );
    io_bridge #(.NUM_PORTS(3), .PORT_BITS(2), .TIMEOUT_CYCLES(TIMEOUT)) dut3 (
        .clk (clk), .reset (reset), .bus (bus3.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an IO access completes once ready is seen or after it
    // has already stalled TIMEOUT cycles; results appear one cycle later.
    int              age      = 0;
    logic            m_last   = 1'b0;
    logic [18:0]     m_cap    = '0;
    logic            m_berr   = 1'b0;
    logic [3:0]      m_eport  = '0;
    int              m_port;
    logic            m_hit, m_rdy, m_done, m_bad;
    logic [3:0]      m_sel;

    always @(negedge clk) begin
        m_port = int'(bus.core_addr[11:10]);
        m_hit  = bus.core_valid && (bus.core_addr[15:12] == 4'hF);
        m_rdy  = bus.io_ready[m_port];
        m_done = m_hit && (m_rdy || age == TIMEOUT);
        m_bad  = m_hit && !m_rdy && (age == TIMEOUT);
        m_sel  = (m_hit && !reset) ? (4'b0001 << m_port) : 4'b0000;

        chk("model_stall", 32'(bus.core_stall), 32'(!reset && m_hit && !m_done));
        chk("model_sel",   32'(bus.io_sel), 32'(m_sel));
        chk("model_rd",    32'(bus.io_read),  32'(!reset && m_hit && !bus.core_write));
        chk("model_wr",    32'(bus.io_write), 32'(!reset && m_hit && bus.core_write));
        chk("model_ramwr", 32'(bus.ram_write),
            32'(!reset && bus.core_valid && bus.core_write && !m_hit));
        chk("model_rdata", 32'(bus.core_rdata), 32'(m_last ? m_cap : bus.ram_rdata));
        chk("model_berr",  32'(bus.bus_error), 32'(m_berr));
        chk("model_eport", 32'(bus.err_port), 32'(m_eport));

        if (reset) begin
            age = 0; m_last = 0; m_cap = '0; m_berr = 0; m_eport = '0;
        end else begin
            age    = (m_hit && !m_done) ? age + 1 : 0;
            m_last = m_done;
            m_berr = m_bad;
            if (m_bad) m_eport = 4'(m_port);
            if (m_done && !bus.core_write)
                m_cap = m_bad ? 19'h0DEAD : {3'b000, bus.io_rdata[m_port*16 +: 16]};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.core_valid = 1'b0;
        bus.core_write = 1'b0;
        bus.io_ready   = '0;
    endtask

    task automatic io_acc(input logic [15:0] addr, input logic wr, input logic [18:0] wd);
        bus.core_addr  = addr;
        bus.core_valid = 1'b1;
        bus.core_write = wr;
        bus.core_wdata = wd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_stall, n_wr;

    initial begin
        bus.core_addr  = 16'hF805;
        bus.core_valid = 1'b1;
        bus.core_write = 1'b1;
        bus.core_wdata = '0;
        bus.ram_rdata  = 19'h00055;
        bus.io_rdata   = {16'h3333, 16'h2222, 16'h1234, 16'h1111};
        bus.io_ready   = '0;
        bus3.core_addr  = '0;
        bus3.core_valid = 1'b0;
        bus3.core_write = 1'b0;
        bus3.core_wdata = '0;
        bus3.ram_rdata  = '0;
        bus3.io_rdata   = {16'hCCCC, 16'hBBBB, 16'hAAAA};
        bus3.io_ready   = '0;

        // Reset forces strobes low even with an IO request present.
        tick(); tick();
        #1;
        chk("rst_stall", 32'(bus.core_stall), 32'd0);
        chk("rst_sel",   32'(bus.io_sel), 32'd0);
        chk("rst_wr",    32'(bus.io_write), 32'd0);
        chk("rst_ramwr", 32'(bus.ram_write), 32'd0);
        chk("rst_berr",  32'(bus.bus_error), 32'd0);
        chk("rst_eport", 32'(bus.err_port), 32'd0);
        chk("rst_rdata", 32'(bus.core_rdata), 32'h00055);

        tick();
        reset = 1'b0;
        idle();
        tick();

        // Zero-wait read from port 1.
        io_acc(16'hF405, 1'b0, '0);
        bus.io_ready = 4'b0010;
        #1;
        chk("zw_sel",   32'(bus.io_sel), 32'b0010);
        chk("zw_index", 32'(bus.io_index), 32'h405);
        chk("zw_stall", 32'(bus.core_stall), 32'd0);
        chk("zw_read",  32'(bus.io_read), 32'd1);
        tick();
        idle();
        #1;
        chk("zw_rdata", 32'(bus.core_rdata), 32'h01234);
        chk("zw_berr",  32'(bus.bus_error), 32'd0);
        tick();

        // Write to port 2 with ready held low for three cycles.
        io_acc(16'hF805, 1'b1, 19'h0ABCD);
        n_stall = 0; n_wr = 0;
        for (int i = 0; i < 4; i++) begin
            bus.io_ready = (i == 3) ? 4'b0100 : 4'b0000;
            #1;
            if (bus.core_stall) n_stall++;
            if (bus.io_write)   n_wr++;
            if (i == 0) chk("ws_wdata", 32'(bus.io_wdata), 32'hABCD);
            tick();
        end
        chk("ws_stall_cycles", 32'(n_stall), 32'd3);
        chk("ws_write_cycles", 32'(n_wr), 32'd4);
        idle();
        #1;
        chk("ws_berr", 32'(bus.bus_error), 32'd0);
        tick();

        // Read from port 3 that never becomes ready.
        io_acc(16'hFC00, 1'b0, '0);
        n_stall = 0;
        for (int i = 0; i < TIMEOUT + 1; i++) begin
            #1;
            if (bus.core_stall) n_stall++;
            if (i == TIMEOUT) chk("to_last_stall", 32'(bus.core_stall), 32'd0);
            tick();
        end
        chk("to_stall_cycles", 32'(n_stall), 32'd15);
        idle();
        #1;
        chk("to_rdata", 32'(bus.core_rdata), 32'h0DEAD);
        chk("to_berr",  32'(bus.bus_error), 32'd1);
        chk("to_eport", 32'(bus.err_port), 32'd3);
        tick();
        chk("to_berr_drop", 32'(bus.bus_error), 32'd0);
        chk("to_eport_sticky", 32'(bus.err_port), 32'd3);

        // Port 0 becomes ready exactly when the wait count reaches the limit.
        io_acc(16'hF000, 1'b0, '0);
        n_stall = 0;
        for (int i = 0; i < TIMEOUT + 1; i++) begin
            bus.io_ready = (i == TIMEOUT) ? 4'b0001 : 4'b0000;
            #1;
            if (bus.core_stall) n_stall++;
            tick();
        end
        chk("lr_stall_cycles", 32'(n_stall), 32'd15);
        idle();
        #1;
        chk("lr_rdata", 32'(bus.core_rdata), 32'h01111);
        chk("lr_berr",  32'(bus.bus_error), 32'd0);
        tick();

        // RAM write then RAM read.
        io_acc(16'h0100, 1'b1, 19'h12345);
        #1;
        chk("ram_wr",     32'(bus.ram_write), 32'd1);
        chk("ram_io_sel", 32'(bus.io_sel), 32'd0);
        chk("ram_io_rw",  32'({bus.io_read, bus.io_write}), 32'd0);
        tick();
        io_acc(16'h0100, 1'b0, '0);
        bus.ram_rdata = 19'h7FFFF;
        #1;
        chk("ram_rd_wr", 32'(bus.ram_write), 32'd0);
        tick();
        idle();
        #1;
        chk("ram_rdata", 32'(bus.core_rdata), 32'h7FFFF);
        tick();

        // Back-to-back zero-wait reads: port 2 then port 1.
        io_acc(16'hF810, 1'b0, '0);
        bus.io_ready = 4'b0100;
        tick();
        io_acc(16'hF420, 1'b0, '0);
        bus.io_ready = 4'b0010;
        #1;
        chk("b2b_rdata0", 32'(bus.core_rdata), 32'h02222);
        tick();
        idle();
        #1;
        chk("b2b_rdata1", 32'(bus.core_rdata), 32'h01234);
        tick();

        // Unmapped port on the three-port instance.
        bus3.core_addr  = 16'hFC10;
        bus3.core_valid = 1'b1;
        #1;
        chk("um_stall", 32'(bus3.core_stall), 32'd0);
        chk("um_sel",   32'(bus3.io_sel), 32'd0);
        chk("um_read",  32'(bus3.io_read), 32'd0);
        tick();
        bus3.core_valid = 1'b0;
        #1;
        chk("um_rdata", 32'(bus3.core_rdata), 32'h0DEAD);
        chk("um_berr",  32'(bus3.bus_error), 32'd1);
        chk("um_eport", 32'(bus3.err_port), 32'd3);
        tick();
        chk("um_berr_drop", 32'(bus3.bus_error), 32'd0);

        // Reset during the second WAIT cycle; err_port (3) must clear.
        io_acc(16'hF805, 1'b0, '0);
        tick(); tick();
        reset = 1'b1;
        #1;
        chk("mr_stall_in_rst", 32'(bus.core_stall), 32'd0);
        tick();
        reset = 1'b0;
        idle();
        #1;
        chk("mr_stall", 32'(bus.core_stall), 32'd0);
        chk("mr_sel",   32'(bus.io_sel), 32'd0);
        chk("mr_read",  32'(bus.io_read), 32'd0);
        chk("mr_berr",  32'(bus.bus_error), 32'd0);
        chk("mr_eport", 32'(bus.err_port), 32'd0);
        tick(); tick();
        chk("mr_berr_after", 32'(bus.bus_error), 32'd0);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
